// File: rtl/sc_arbiter_pkg.sv
// sc_arbiter_pkg
// Shared definitions for the player/tick arbiter in front of the game-matrix
// datapath: FSM state encoding, the 2-bit move command codes and the
// shift-select values the matrix register bank understands.
package sc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HOLD  = 2'd3
    } arbState_t;

    localparam logic [1:0] CMD_UP    = 2'd0;
    localparam logic [1:0] CMD_DOWN  = 2'd1;
    localparam logic [1:0] CMD_LEFT  = 2'd2;
    localparam logic [1:0] CMD_RIGHT = 2'd3;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    // Buttons are ordered {right,left,down,up}, so the lowest set bit wins:
    // up > down > left > right.
    function automatic logic [1:0] pickCommand(input logic [3:0] edges);
        logic [1:0] cmd;
        if (edges[0])      cmd = CMD_UP;
        else if (edges[1]) cmd = CMD_DOWN;
        else if (edges[2]) cmd = CMD_LEFT;
        else               cmd = CMD_RIGHT;
        return cmd;
    endfunction

endpackage

// File: rtl/sc_request_capture.sv
// sc_request_capture
// Turns one player's debounced, active-low buttons into a single pending
// request slot.
//   SC_REQUEST_CAPTURE_CLOCK_50    system clock
//   SC_REQUEST_CAPTURE_RESET_InLow asynchronous active-low reset
//   enable        level running; when low the slot is emptied
//   buttons       {right,left,down,up}, active low
//   consume       arbiter takes the slot this cycle
//   pendingValid  slot holds a request
//   pendingCmd    command held in the slot
module sc_request_capture
    import sc_arbiter_pkg::*;
(
    input  logic       SC_REQUEST_CAPTURE_CLOCK_50,
    input  logic       SC_REQUEST_CAPTURE_RESET_InLow,
    input  logic       enable,
    input  logic [3:0] buttons,
    input  logic       consume,
    output logic       pendingValid,
    output logic [1:0] pendingCmd
);

    logic [3:0] prevButtons;
    logic [3:0] pressEdges;
    logic       anyPress;

    // A press is a high-to-low transition of an active-low button.
    assign pressEdges = prevButtons & ~buttons;
    assign anyPress   = |pressEdges;

    // The edge history keeps running while disabled so a button held across
    // a re-enable is not seen as a fresh press. A press only lands in an empty
    // slot or in one being consumed in the same cycle; otherwise it is lost.
    always_ff @(posedge SC_REQUEST_CAPTURE_CLOCK_50 or negedge SC_REQUEST_CAPTURE_RESET_InLow) begin
        if (!SC_REQUEST_CAPTURE_RESET_InLow) begin
            prevButtons  <= 4'b1111;
            pendingValid <= 1'b0;
            pendingCmd   <= CMD_UP;
        end else begin
            prevButtons <= buttons;
            if (!enable) begin
                pendingValid <= 1'b0;
            end else if (anyPress && (!pendingValid || consume)) begin
                pendingValid <= 1'b1;
                pendingCmd   <= pickCommand(pressEdges);
            end else if (consume) begin
                pendingValid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sc_arbiter_jugadores.sv
// sc_arbiter_jugadores
// Shares the game-matrix datapath between two players and the periodic
// auto-shift tick. One one-cycle command per grant, followed by a hold gap.
//   SC_ARBITER_JUGADORES_CLOCK_50    system clock
//   SC_ARBITER_JUGADORES_RESET_InLow asynchronous active-low reset
//   enable_InHigh       level running
//   jug1_req_InLow      player 1 buttons {right,left,down,up}, active low
//   jug2_req_InLow      player 2 buttons, same encoding
//   clear_OutLow        matrix clear
//   load0_OutLow        up command
//   load1_OutLow        down command
//   shiftselection_Out  01 left, 10 right, 11 hold
//   grant_Out           one-hot command source, 00 for tick/clear/none
//   busy_Out            arbiter is in CLEAR, ISSUE or HOLD
module sc_arbiter_jugadores
    import sc_arbiter_pkg::*;
#(
    parameter int TICK_WIDTH  = 24,
    parameter int TICK_PERIOD = 12500000,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       SC_ARBITER_JUGADORES_CLOCK_50,
    input  logic       SC_ARBITER_JUGADORES_RESET_InLow,
    input  logic       enable_InHigh,
    input  logic [3:0] jug1_req_InLow,
    input  logic [3:0] jug2_req_InLow,
    output logic       clear_OutLow,
    output logic       load0_OutLow,
    output logic       load1_OutLow,
    output logic [1:0] shiftselection_Out,
    output logic [1:0] grant_Out,
    output logic       busy_Out
);

    arbState_t             state, nextState;
    logic [TICK_WIDTH-1:0] tickCount;
    logic                  tickPending;
    logic                  enablePrev;
    logic                  rrPointer;
    logic [3:0]            holdCount;
    logic [1:0]            issueCmd, nextCmd;
    logic [1:0]            issueGrant, nextGrant;
    logic                  consumeJug1, consumeJug2, consumeTick;
    logic                  jug1Valid, jug2Valid;
    logic [1:0]            jug1Cmd, jug2Cmd;

    sc_request_capture captureJug1 (
        .SC_REQUEST_CAPTURE_CLOCK_50   (SC_ARBITER_JUGADORES_CLOCK_50),
        .SC_REQUEST_CAPTURE_RESET_InLow(SC_ARBITER_JUGADORES_RESET_InLow),
        .enable      (enable_InHigh),
        .buttons     (jug1_req_InLow),
        .consume     (consumeJug1),
        .pendingValid(jug1Valid),
        .pendingCmd  (jug1Cmd)
    );

    sc_request_capture captureJug2 (
        .SC_REQUEST_CAPTURE_CLOCK_50   (SC_ARBITER_JUGADORES_CLOCK_50),
        .SC_REQUEST_CAPTURE_RESET_InLow(SC_ARBITER_JUGADORES_RESET_InLow),
        .enable      (enable_InHigh),
        .buttons     (jug2_req_InLow),
        .consume     (consumeJug2),
        .pendingValid(jug2Valid),
        .pendingCmd  (jug2Cmd)
    );

    // Auto-shift tick. A new terminal count wins over consumption in the same
    // cycle so no tick is lost; ticks never stack beyond one.
    always_ff @(posedge SC_ARBITER_JUGADORES_CLOCK_50 or negedge SC_ARBITER_JUGADORES_RESET_InLow) begin
        if (!SC_ARBITER_JUGADORES_RESET_InLow) begin
            tickCount   <= '0;
            tickPending <= 1'b0;
        end else if (!enable_InHigh) begin
            tickCount   <= '0;
            tickPending <= 1'b0;
        end else if (tickCount == TICK_WIDTH'(TICK_PERIOD - 1)) begin
            tickCount   <= '0;
            tickPending <= 1'b1;
        end else begin
            tickCount <= tickCount + TICK_WIDTH'(1);
            if (consumeTick) tickPending <= 1'b0;
        end
    end

    // State register plus the bookkeeping that follows each grant.
    always_ff @(posedge SC_ARBITER_JUGADORES_CLOCK_50 or negedge SC_ARBITER_JUGADORES_RESET_InLow) begin
        if (!SC_ARBITER_JUGADORES_RESET_InLow) begin
            state      <= ST_IDLE;
            enablePrev <= 1'b0;
            rrPointer  <= 1'b0;
            holdCount  <= 4'd0;
            issueCmd   <= CMD_DOWN;
            issueGrant <= 2'b00;
        end else begin
            state      <= nextState;
            enablePrev <= enable_InHigh;
            if (consumeJug1 || consumeJug2) rrPointer <= ~rrPointer;
            if (consumeJug1 || consumeJug2 || consumeTick) begin
                issueCmd   <= nextCmd;
                issueGrant <= nextGrant;
            end
            holdCount <= (state == ST_HOLD && nextState == ST_HOLD) ? holdCount + 4'd1 : 4'd0;
        end
    end

    // Next state and grant selection. The tick outranks players; between
    // players the round-robin pointer only matters when both are waiting.
    always_comb begin
        nextState   = state;
        nextCmd     = CMD_DOWN;
        nextGrant   = 2'b00;
        consumeJug1 = 1'b0;
        consumeJug2 = 1'b0;
        consumeTick = 1'b0;
        if (!enable_InHigh) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!enablePrev) begin
                        nextState = ST_CLEAR;
                    end else if (tickPending) begin
                        nextState   = ST_ISSUE;
                        consumeTick = 1'b1;
                    end else if (jug1Valid && (!jug2Valid || !rrPointer)) begin
                        nextState   = ST_ISSUE;
                        nextCmd     = jug1Cmd;
                        nextGrant   = 2'b01;
                        consumeJug1 = 1'b1;
                    end else if (jug2Valid) begin
                        nextState   = ST_ISSUE;
                        nextCmd     = jug2Cmd;
                        nextGrant   = 2'b10;
                        consumeJug2 = 1'b1;
                    end
                end
                ST_CLEAR: nextState = ST_HOLD;
                ST_ISSUE: nextState = ST_HOLD;
                ST_HOLD: begin
                    if (holdCount == 4'(HOLD_CYCLES - 1)) nextState = ST_IDLE;
                end
                default: nextState = ST_IDLE;
            endcase
        end
    end

    // Moore output decode: only the state and the latched grant drive the
    // datapath, so an asynchronous reset drops a command immediately.
    always_comb begin
        clear_OutLow       = 1'b1;
        load0_OutLow       = 1'b1;
        load1_OutLow       = 1'b1;
        shiftselection_Out = SHIFT_HOLD;
        grant_Out          = 2'b00;
        busy_Out           = (state != ST_IDLE);
        if (state == ST_CLEAR) begin
            clear_OutLow = 1'b0;
        end else if (state == ST_ISSUE) begin
            grant_Out = issueGrant;
            case (issueCmd)
                CMD_UP:   load0_OutLow       = 1'b0;
                CMD_DOWN: load1_OutLow       = 1'b0;
                CMD_LEFT: shiftselection_Out = SHIFT_LEFT;
                default:  shiftselection_Out = SHIFT_RIGHT;
            endcase
        end
    end

endmodule
